// File: rtl/e_pkg.sv
// Shared types for the unary encoder: skid-buffer state, per-beat sideband and the
// count-width helper.
package e_pkg;

  typedef enum logic [1:0] {
    StEmpty,
    StOne,
    StFull
  } skid_st_e;

  // Sideband that travels with each encoded vector through the skid buffer.
  typedef struct packed {
    logic is_compliment;
    logic err;
  } beat_meta_t;

  function automatic int unsigned cnt_w(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/e_bin2unary.sv
// Combinational binary-to-unary converter with range saturation and optional complement.
module e_bin2unary
  import e_pkg::*;
#(
  parameter int unsigned W                     = 16,
  parameter bit          P_ADMIT_COMPLIMENT_EN = 1'b0,
  localparam int unsigned CW                   = cnt_w(W)
) (
  input  logic [CW-1:0] i_cnt,
  input  logic          i_compliment,
  output logic [W-1:0]  o_x,
  output logic          o_is_compliment,
  output logic          o_err
);

  localparam int unsigned WM1 = W - 1;
  localparam logic [CW:0]   WLim = W[CW:0];
  localparam logic [CW-1:0] KMax = WM1[CW-1:0];

  logic          w_over;
  logic          w_cmp;
  logic [CW-1:0] w_kk;
  logic [W-1:0]  w_norm;

  always_comb begin
    w_over = ({1'b0, i_cnt} >= WLim);
    w_kk   = w_over ? KMax : i_cnt;
    w_cmp  = P_ADMIT_COMPLIMENT_EN & i_compliment;
    w_norm = '0;
    for (int unsigned j = 0; j < W; j++) begin
      w_norm[j] = (j < 32'(w_kk));
    end
    o_x             = w_cmp ? ~w_norm : w_norm;
    o_is_compliment = w_cmp;
    o_err           = w_over;
  end

endmodule

// File: rtl/e_unary_enc.sv
// Unary/thermometer encoder behind a 2-entry skid buffer; i_rdy is registered-only so the
// block can sit on pipeline boundaries without a combinational ready path.
module e_unary_enc
  import e_pkg::*;
#(
  parameter int unsigned W                     = 16,
  parameter bit          P_ADMIT_COMPLIMENT_EN = 1'b0,
  parameter int unsigned P_ERR_CNT_W           = 8,
  localparam int unsigned CW                   = cnt_w(W)
) (
  input  logic                   clk,
  input  logic                   arst_n,
  input  logic                   i_vld,
  output logic                   i_rdy,
  input  logic [CW-1:0]          i_cnt,
  input  logic                   i_compliment,
  output logic                   o_vld,
  input  logic                   o_rdy,
  output logic [W-1:0]           o_x,
  output logic                   o_is_compliment,
  output logic                   o_err,
  output logic [P_ERR_CNT_W-1:0] o_err_cnt
);

  typedef struct packed {
    logic [W-1:0] x;
    beat_meta_t   meta;
  } beat_t;

  skid_st_e r_state, w_state_nxt;
  beat_t    r_out, r_skid, w_in;
  logic     w_acc, w_xfer;
  logic     w_x_isc, w_x_err;
  logic [W-1:0] w_x;
  logic [P_ERR_CNT_W-1:0] r_err_cnt;

  e_bin2unary #(
    .W                    (W),
    .P_ADMIT_COMPLIMENT_EN(P_ADMIT_COMPLIMENT_EN)
  ) u_bin2unary (
    .i_cnt          (i_cnt),
    .i_compliment   (i_compliment),
    .o_x            (w_x),
    .o_is_compliment(w_x_isc),
    .o_err          (w_x_err)
  );

  always_comb begin
    w_in.x                  = w_x;
    w_in.meta.is_compliment = w_x_isc;
    w_in.meta.err           = w_x_err;
  end

  // State register
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state <= StEmpty;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StEmpty: if (w_acc) w_state_nxt = StOne;
      StOne: begin
        if (w_acc && !w_xfer) begin
          w_state_nxt = StFull;
        end else if (!w_acc && w_xfer) begin
          w_state_nxt = StEmpty;
        end
      end
      StFull: if (w_xfer) w_state_nxt = StOne;
      default: w_state_nxt = StEmpty;
    endcase
  end

  // Outputs and handshake qualifiers
  always_comb begin
    i_rdy           = (r_state != StFull);
    o_vld           = (r_state != StEmpty);
    w_acc           = i_vld & i_rdy;
    w_xfer          = o_vld & o_rdy;
    o_x             = r_out.x;
    o_is_compliment = r_out.meta.is_compliment;
    o_err           = r_out.meta.err;
    o_err_cnt       = r_err_cnt;
  end

  // Out reg takes the new beat when it is free or being drained this cycle; otherwise the
  // beat parks in the skid reg until the head leaves.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_out  <= '0;
      r_skid <= '0;
    end else begin
      if (w_acc && (r_state == StEmpty || w_xfer)) begin
        r_out <= w_in;
      end else if (r_state == StFull && w_xfer) begin
        r_out <= r_skid;
      end
      if (w_acc && !w_xfer && r_state == StOne) begin
        r_skid <= w_in;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_err_cnt <= '0;
    end else if (w_acc && w_x_err && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_e_unary_enc.sv
// Scoreboard bench for e_unary_enc (W=12): expected beats are queued at accept and
// compared at transfer, alongside directed checks of reset, saturation and back-pressure.
module tb_e_unary_enc;

  localparam int unsigned W  = 12;
  localparam int unsigned CW = 4;
  localparam int unsigned EW = 2;

  typedef struct packed {
    logic [W-1:0] x;
    logic         isc;
    logic         err;
  } exp_t;

  logic          clk = 1'b0;
  logic          arst_n;
  logic          i_vld, i_compliment, o_rdy;
  logic [CW-1:0] i_cnt;
  logic          i_rdy, o_vld, o_is_compliment, o_err;
  logic [W-1:0]  o_x;
  logic [EW-1:0] o_err_cnt;
  logic          nc_i_rdy, nc_o_vld, nc_o_isc, nc_o_err;
  logic [W-1:0]  nc_o_x;
  logic [7:0]    nc_err_cnt;

  exp_t          sb_q[$];
  int            n_tests = 0;
  int            n_fail  = 0;
  int            n_xfer  = 0;
  int            cyc     = 0;
  logic [EW-1:0] exp_err_cnt = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  e_unary_enc #(
    .W                    (W),
    .P_ADMIT_COMPLIMENT_EN(1'b1),
    .P_ERR_CNT_W          (EW)
  ) dut (
    .clk            (clk),
    .arst_n         (arst_n),
    .i_vld          (i_vld),
    .i_rdy          (i_rdy),
    .i_cnt          (i_cnt),
    .i_compliment   (i_compliment),
    .o_vld          (o_vld),
    .o_rdy          (o_rdy),
    .o_x            (o_x),
    .o_is_compliment(o_is_compliment),
    .o_err          (o_err),
    .o_err_cnt      (o_err_cnt)
  );

  // Complement disabled; same stimulus so it runs in lockstep with dut.
  e_unary_enc #(
    .W                    (W),
    .P_ADMIT_COMPLIMENT_EN(1'b0),
    .P_ERR_CNT_W          (8)
  ) dut_nc (
    .clk            (clk),
    .arst_n         (arst_n),
    .i_vld          (i_vld),
    .i_rdy          (nc_i_rdy),
    .i_cnt          (i_cnt),
    .i_compliment   (i_compliment),
    .o_vld          (nc_o_vld),
    .o_rdy          (o_rdy),
    .o_x            (nc_o_x),
    .o_is_compliment(nc_o_isc),
    .o_err          (nc_o_err),
    .o_err_cnt      (nc_err_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [CW-1:0] cnt, input logic cmp);
    exp_t        e;
    int unsigned kk;
    e.err = (32'(cnt) >= W);
    kk    = e.err ? W - 1 : 32'(cnt);
    e.x   = '0;
    for (int unsigned j = 0; j < kk; j++) e.x[j] = 1'b1;
    e.isc = cmp;
    if (e.isc) e.x = ~e.x;
    return e;
  endfunction

  // Independent admission rule: de-complemented vector is a low-aligned run of ones.
  function automatic bit admissible(input logic [W-1:0] x, input logic isc);
    logic [W-1:0] y;
    logic [W-1:0] one;
    one = {{(W - 1){1'b0}}, 1'b1};
    y   = isc ? ~x : x;
    if ((y & (y + one)) != '0) return 1'b0;
    if (x == '0) return !isc;
    return isc == x[W-1];
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!arst_n) begin
        sb_q.delete();
        exp_err_cnt = '0;
      end else begin
        check_eq("o_vld", 32'(o_vld), 32'(sb_q.size() != 0));
        check_eq("i_rdy", 32'(i_rdy), 32'(sb_q.size() < 2));
        check_eq("err_cnt", 32'(o_err_cnt), 32'(exp_err_cnt));
        if (o_vld && o_rdy && sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check_eq("sb_x", 32'(o_x), 32'(e.x));
          check_eq("sb_isc", 32'(o_is_compliment), 32'(e.isc));
          check_eq("sb_err", 32'(o_err), 32'(e.err));
          check_eq("admit", 32'(admissible(o_x, o_is_compliment)), 32'd1);
          n_xfer++;
        end
        if (i_vld && i_rdy) begin
          e = model(i_cnt, i_compliment);
          sb_q.push_back(e);
          if (e.err && exp_err_cnt != '1) exp_err_cnt++;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int cnt, input logic cmp);
    bit got = 1'b0;
    i_vld        = 1'b1;
    i_cnt        = cnt[CW-1:0];
    i_compliment = cmp;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      got = i_rdy;
      @(posedge clk);
      #1;
    end
    i_vld = 1'b0;
    check_eq("accept", 32'(got), 32'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int c0, x0;
    arst_n       = 1'b0;
    i_vld        = 1'b0;
    i_cnt        = '0;
    i_compliment = 1'b0;
    o_rdy        = 1'b0;
    #12;
    check_eq("rst_o_vld", 32'(o_vld), 32'd0);
    check_eq("rst_i_rdy", 32'(i_rdy), 32'd1);
    check_eq("rst_o_x", 32'(o_x), 32'd0);
    check_eq("rst_isc", 32'(o_is_compliment), 32'd0);
    check_eq("rst_err", 32'(o_err), 32'd0);
    check_eq("rst_err_cnt", 32'(o_err_cnt), 32'd0);
    @(posedge clk);
    #1;
    arst_n = 1'b1;
    o_rdy  = 1'b1;

    // Basic encode, one-cycle latency
    send(5, 1'b0);
    check_eq("t1_vld", 32'(o_vld), 32'd1);
    check_eq("t1_x", 32'(o_x), 32'h01F);
    check_eq("t1_isc", 32'(o_is_compliment), 32'd0);
    check_eq("t1_err", 32'(o_err), 32'd0);

    // Complement form and the disabled-complement instance
    send(0, 1'b1);
    check_eq("t2_x0", 32'(o_x), 32'hFFF);
    check_eq("t2_isc0", 32'(o_is_compliment), 32'd1);
    check_eq("t2_nc_x0", 32'(nc_o_x), 32'h000);
    send(3, 1'b1);
    check_eq("t2_x3", 32'(o_x), 32'hFF8);
    check_eq("t2_nc_x3", 32'(nc_o_x), 32'h007);
    check_eq("t2_nc_isc", 32'(nc_o_isc), 32'd0);

    // Out-of-range saturation and error counter
    send(13, 1'b0);
    check_eq("t3_x", 32'(o_x), 32'h7FF);
    check_eq("t3_err", 32'(o_err), 32'd1);
    check_eq("t3_cnt1", 32'(o_err_cnt), 32'd1);
    check_eq("t3_nc_err", 32'(nc_o_err), 32'd1);
    for (int i = 0; i < 4; i++) send(12 + i, 1'b0);
    check_eq("t3_cnt_sat", 32'(o_err_cnt), 32'd3);
    check_eq("t3_nc_cnt", 32'(nc_err_cnt), 32'd5);

    // Back-pressure fills the skid buffer
    tick(2);
    o_rdy = 1'b0;
    send(1, 1'b0);
    send(2, 1'b0);
    i_vld = 1'b1;
    i_cnt = 4'd3;
    tick(2);
    check_eq("t4_rdy_low", 32'(i_rdy), 32'd0);
    check_eq("t4_hold_x", 32'(o_x), 32'h001);
    check_eq("t4_nc_rdy", 32'(nc_i_rdy), 32'd0);
    check_eq("t4_nc_vld", 32'(nc_o_vld), 32'd1);
    o_rdy = 1'b1;
    send(3, 1'b0);
    tick(4);

    // Full-throughput sweep
    c0 = cyc;
    x0 = n_xfer;
    for (int k = 0; k < 12; k++) send(k, 1'b0);
    check_eq("t5_cycles", 32'(cyc - c0), 32'd12);
    tick(1);
    check_eq("t5_xfers", 32'(n_xfer - x0), 32'd12);

    // Reset while full
    o_rdy = 1'b0;
    send(4, 1'b1);
    send(6, 1'b0);
    check_eq("t6_full", 32'(i_rdy), 32'd0);
    #3;
    arst_n = 1'b0;
    #1;
    check_eq("t6_o_vld", 32'(o_vld), 32'd0);
    check_eq("t6_i_rdy", 32'(i_rdy), 32'd1);
    check_eq("t6_o_x", 32'(o_x), 32'd0);
    tick(2);
    arst_n = 1'b1;
    o_rdy  = 1'b1;
    tick(5);
    check_eq("t6_no_stale", 32'(o_vld), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
